// File: rtl/key_led_ctrl.sv
// key_led_ctrl: four independent key lanes, each synchronised, debounced and
// driving one registered LED output.
// Build option: define KEY_LED_TOGGLE_EN to make each debounced press invert
// its LED; left undefined, each LED mirrors its debounced key level.

// One key lane: 2-flop synchroniser, debounce counter, LED state.
module key_led_lane #(
    parameter int DB_CNT         = 1,
    parameter int KEY_ACTIVE_LOW = 0,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic led
);
    localparam int            CW       = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);
    localparam logic          KEY_INV  = (KEY_ACTIVE_LOW != 0);
    localparam logic          LED_INV  = (LED_ACTIVE_LOW != 0);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          db_q, db_d;
    logic          l_q, l_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronise the normalised key and debounce it; any agreement between
    // s2 and the debounced level drops a partial count.
    always_comb begin
        s1_d  = key ^ KEY_INV;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // LED state: toggle on the debounced rising edge, or mirror the level.
    always_comb begin
`ifdef KEY_LED_TOGGLE_EN
        l_d = l_q ^ (db_d & ~db_q);
`else
        l_d = db_q;
`endif
    end

    // Lane state registers; reset leaves every LED dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
            l_q   <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            cnt_q <= cnt_d;
            l_q   <= l_d;
        end
    end

    assign led = l_q ^ LED_INV;
endmodule

// Top: one lane instance per board key.
module key_led_ctrl #(
    parameter int DB_CNT         = 1,
    parameter int KEY_ACTIVE_LOW = 0,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    output logic [3:0] led
);
    localparam int NUM_LANES = 4;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        key_led_lane #(
            .DB_CNT        (DB_CNT),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
            .LED_ACTIVE_LOW(LED_ACTIVE_LOW)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .key  (key[i]),
            .led  (led[i])
        );
    end
endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl: instance A (DB_CNT=1, active-high pins) and
// instance B (DB_CNT=4, active-low pins), a window-based reference model,
// a vector table, hand sequences and random key traffic.
module tb_key_led_ctrl;
    localparam int D_A = 1;
    localparam int D_B = 4;
`ifdef KEY_LED_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_a = 4'h0;
    logic [3:0] key_b = 4'hF;
    logic [3:0] led_a, led_b;
    int checks   = 0;
    int failures = 0;

    key_led_ctrl #(.DB_CNT(D_A), .KEY_ACTIVE_LOW(0), .LED_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .key(key_a), .led(led_a));
    key_led_ctrl #(.DB_CNT(D_B), .KEY_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .key(key_b), .led(led_b));

    always #5 clk = ~clk;

    // Reference model: per key, the recent pressed/not-pressed samples. The
    // debounced level takes value v once the D samples that have reached the
    // synchroniser output over the last D edges all equal v.
    bit hist [2][4][6];
    bit db_m [2][4];
    bit l_m  [2][4];
    int dd   [2] = '{D_A, D_B};
    bit kal  [2] = '{1'b0, 1'b1};
    bit lal  [2] = '{1'b0, 1'b1};

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 4; k++) begin
                db_m[m][k] = 1'b0;
                l_m[m][k]  = 1'b0;
                for (int j = 0; j < 6; j++) hist[m][k][j] = 1'b0;
            end
    endtask

    task automatic model_step(input int m, input logic [3:0] kv);
        for (int k = 0; k < 4; k++) begin
            bit nk, all1, all0, prev;
            int len;
            len  = dd[m] + 2;
            nk   = kv[k] ^ kal[m];
            for (int j = 0; j < len - 1; j++) hist[m][k][j] = hist[m][k][j+1];
            hist[m][k][len-1] = nk;
            all1 = 1'b1;
            all0 = 1'b1;
            for (int j = 0; j < dd[m]; j++) begin
                all1 &= hist[m][k][j];
                all0 &= ~hist[m][k][j];
            end
            prev = db_m[m][k];
            if (all1) db_m[m][k] = 1'b1;
            else if (all0) db_m[m][k] = 1'b0;
            if (TOG) begin
                if (!prev && db_m[m][k]) l_m[m][k] = ~l_m[m][k];
            end else begin
                l_m[m][k] = prev;
            end
        end
    endtask

    function automatic logic [3:0] exp_led(input int m);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = l_m[m][k] ^ lal[m];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance the model on the edge, compare after.
    task automatic step(input logic [3:0] ka, input logic [3:0] kb);
        @(negedge clk);
        key_a = ka;
        key_b = kb;
        @(posedge clk);
        model_step(0, ka);
        model_step(1, kb);
        #1;
        chk("model_a", led_a, exp_led(0));
        chk("model_b", led_b, exp_led(1));
    endtask

    // Async reset asserted off the clock edge, held 3 cycles with all keys high.
    task automatic do_reset();
        @(negedge clk);
        #2;
        key_a = 4'hF;
        key_b = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("rst_async_a", led_a, 4'h0);
        chk("rst_async_b", led_b, 4'hF);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_a", led_a, 4'h0);
            chk("rst_hold_b", led_b, 4'hF);
        end
        @(negedge clk);
        key_a = 4'h0;
        key_b = 4'hF;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] ka;
        logic [3:0] exp_m;
        logic [3:0] exp_t;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   ch_a [4];
        int   ch_b [4];
        int   rises;
        bit   prev0, seen;
        logic [3:0] acc;

        // Walking key on A: mirror shows each key 3 edges later for 1 cycle;
        // toggle latches each LED on at the edge its debounced level rises.
        tbl[0] = '{4'b0001, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0010, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0100, 4'b0000, 4'b0001};
        tbl[3] = '{4'b1000, 4'b0001, 4'b0011};
        tbl[4] = '{4'b0000, 4'b0010, 4'b0111};
        tbl[5] = '{4'b0000, 4'b0100, 4'b1111};
        tbl[6] = '{4'b0000, 4'b1000, 4'b1111};
        tbl[7] = '{4'b0000, 4'b0000, 4'b1111};
        tbl[8] = '{4'b0000, 4'b0000, 4'b1111};
        tbl[9] = '{4'b0000, 4'b0000, 4'b1111};

        model_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].ka, 4'hF);
            chk("walk_a", led_a, TOG ? tbl[i].exp_t : tbl[i].exp_m);
            chk("idle_b", led_b, 4'hF);
        end

        // All keys pressed together: every LED changes at the same edge.
        do_reset();
        for (int k = 0; k < 4; k++) begin ch_a[k] = -1; ch_b[k] = -1; end
        for (int i = 0; i < 9; i++) begin
            step(4'hF, 4'h0);
            for (int k = 0; k < 4; k++) begin
                if (ch_a[k] < 0 && led_a[k] !== 1'b0) ch_a[k] = i;
                if (ch_b[k] < 0 && led_b[k] !== 1'b1) ch_b[k] = i;
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk_int("simul_edge_a", ch_a[k], D_A + (TOG ? 1 : 2));
            chk_int("simul_edge_b", ch_b[k], D_B + (TOG ? 1 : 2));
        end

        // Two short presses on key 0 of A.
        do_reset();
        step(4'b0001, 4'hF);
        for (int i = 0; i < 4; i++) step(4'b0000, 4'hF);
        chk("press1_a", led_a, TOG ? 4'b0001 : 4'b0000);
        step(4'b0001, 4'hF);
        for (int i = 0; i < 4; i++) step(4'b0000, 4'hF);
        chk("press2_a", led_a, 4'b0000);

        // Key 0 held for 10 cycles: LED 0 rises exactly once.
        rises = 0;
        prev0 = led_a[0];
        for (int i = 0; i < 16; i++) begin
            step(i < 10 ? 4'b0001 : 4'b0000, 4'hF);
            if (!prev0 && led_a[0] === 1'b1) rises++;
            prev0 = led_a[0];
        end
        chk_int("hold_rises_a", rises, 1);

        // B, DB_CNT=4: a 3-cycle pulse on key 2 never reaches the LEDs.
        do_reset();
        acc = 4'hF;
        for (int i = 0; i < 14; i++) begin
            step(4'h0, i < 3 ? 4'b1011 : 4'b1111);
            acc &= led_b;
        end
        chk("glitch3_b", acc, 4'hF);

        // B: a 6-cycle pulse on key 2 does light LED 2.
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(4'h0, i < 6 ? 4'b1011 : 4'b1111);
            if (led_b[2] === 1'b0) seen = 1'b1;
        end
        chk_int("pulse6_b", int'(seen), 1);

        // B polarity: key 1 pulled low lights LED 1 (driven 0).
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(4'h0, 4'b1101);
            if (led_b[1] === 1'b0) seen = 1'b1;
        end
        chk_int("polarity_b", int'(seen), 1);

        // Random key traffic with random hold lengths; one reset mid-stream.
        for (int blk = 0; blk < 80; blk++) begin
            logic [3:0] ra, rb;
            int hold;
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 7));
            if (blk == 40) do_reset();
            for (int h = 0; h < hold; h++) step(ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
